// File: rtl/axi_write_arbiter_pkg.sv
// Shared types and constants for the AXI4 write-port arbiter.
// Holds the FSM state encoding, the AXI response codes and the burst length width.
package axi_write_arbiter_pkg;

    localparam int AXI_LEN_WIDTH = 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/axi_write_arbiter_rr.sv
// Combinational round-robin picker.
// Takes the request vector and the one-hot previous owner, and returns a one-hot grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_last,
    output logic [N-1:0] o_grant
);

    logic [N-1:0] w_hiMask;
    logic [N-1:0] w_reqHi;

    // w_hiMask marks every index strictly above the previous owner.
    always_comb begin
        logic w_acc;
        w_hiMask = '0;
        w_acc    = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_hiMask[i] = w_acc;
            w_acc       = w_acc | i_last[i];
        end
    end

    assign w_reqHi = i_req & w_hiMask;

    // Lowest set bit above the previous owner, otherwise wrap to the lowest requester.
    assign o_grant = (|w_reqHi) ? (w_reqHi & (~w_reqHi + 1'b1))
                                : (i_req   & (~i_req   + 1'b1));

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one AXI4 write port between NUM_MASTERS recorders, one burst at a time.
// The grant is round-robin per burst and is held from the AW handshake through the B response.
module axi_write_arbiter
    import axi_write_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 128
) (
    input  logic                                  clk,
    input  logic                                  aresetn,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] s_AWADDR,
    input  logic [NUM_MASTERS*AXI_LEN_WIDTH-1:0]  s_AWLEN,
    input  logic [NUM_MASTERS-1:0]                s_AWVALID,
    output logic [NUM_MASTERS-1:0]                s_AWREADY,
    input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] s_WDATA,
    input  logic [NUM_MASTERS-1:0]                s_WLAST,
    input  logic [NUM_MASTERS-1:0]                s_WVALID,
    output logic [NUM_MASTERS-1:0]                s_WREADY,
    output logic [NUM_MASTERS*2-1:0]              s_BRESP,
    output logic [NUM_MASTERS-1:0]                s_BVALID,
    output logic [AXI_ADDR_WIDTH-1:0]             m_AWADDR,
    output logic [AXI_LEN_WIDTH-1:0]              m_AWLEN,
    output logic                                  m_AWVALID,
    input  logic                                  m_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]             m_WDATA,
    output logic                                  m_WLAST,
    output logic                                  m_WVALID,
    input  logic                                  m_WREADY,
    input  logic [1:0]                            m_BRESP,
    input  logic                                  m_BVALID,
    output logic                                  m_BREADY,
    output logic [NUM_MASTERS-1:0]                grant,
    output logic                                  protocolError,
    input  logic                                  errorClear
);

    localparam int N  = NUM_MASTERS;
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int LW = AXI_LEN_WIDTH;

    state_t        r_state, w_nextState;
    logic [N-1:0]  r_grant, r_lastGrant, w_arbGrant;
    logic [LW-1:0] r_beatsLeft;
    logic          r_protocolError;

    logic [AW-1:0] w_selAddr;
    logic [LW-1:0] w_selLen;
    logic [DW-1:0] w_selWdata;
    logic          w_selAwvalid, w_selWvalid, w_selWlast;
    logic          w_awHs, w_wHs, w_lenDone, w_errSet;

    rr_arbiter #(.N(N)) u_rr (
        .i_req   (s_AWVALID),
        .i_last  (r_lastGrant),
        .o_grant (w_arbGrant)
    );

    // One-hot AND-OR mux of the owner's request and data signals.
    always_comb begin
        w_selAddr    = '0;
        w_selLen     = '0;
        w_selWdata   = '0;
        w_selAwvalid = 1'b0;
        w_selWvalid  = 1'b0;
        w_selWlast   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_selAddr    = w_selAddr  | s_AWADDR[i*AW +: AW];
                w_selLen     = w_selLen   | s_AWLEN[i*LW +: LW];
                w_selWdata   = w_selWdata | s_WDATA[i*DW +: DW];
                w_selAwvalid = w_selAwvalid | s_AWVALID[i];
                w_selWvalid  = w_selWvalid  | s_WVALID[i];
                w_selWlast   = w_selWlast   | s_WLAST[i];
            end
        end
    end

    assign w_awHs    = (r_state == S_ADDR) && w_selAwvalid && m_AWREADY;
    assign w_wHs     = (r_state == S_DATA) && w_selWvalid && m_WREADY;
    assign w_lenDone = (r_beatsLeft == '0);

    always_comb begin
        w_nextState = r_state;
        w_errSet    = 1'b0;
        case (r_state)
            S_IDLE: if (|s_AWVALID) w_nextState = S_ADDR;
            S_ADDR: if (w_awHs) w_nextState = S_DATA;
            S_DATA: begin
                // The burst ends on the master's WLAST or when AWLEN+1 beats are done,
                // whichever comes first; any disagreement between the two is an error.
                if (w_wHs && (w_selWlast || w_lenDone)) begin
                    w_nextState = S_RESP;
                    w_errSet    = !(w_selWlast && w_lenDone);
                end
            end
            S_RESP: if (m_BVALID) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state         <= S_IDLE;
            r_grant         <= '0;
            r_lastGrant     <= {1'b1, {(N-1){1'b0}}};
            r_beatsLeft     <= '0;
            r_protocolError <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_IDLE && |s_AWVALID)
                r_grant <= w_arbGrant;
            if (r_state == S_RESP && m_BVALID) begin
                r_lastGrant <= r_grant;
                r_grant     <= '0;
            end
            if (w_awHs)
                r_beatsLeft <= w_selLen;
            else if (w_wHs)
                r_beatsLeft <= r_beatsLeft - 1'b1;
            if (w_errSet)
                r_protocolError <= 1'b1;
            else if (errorClear)
                r_protocolError <= 1'b0;
        end
    end

    assign m_AWADDR  = w_selAddr;
    assign m_AWLEN   = w_selLen;
    assign m_AWVALID = (r_state == S_ADDR) && w_selAwvalid;
    assign m_WDATA   = w_selWdata;
    assign m_WVALID  = (r_state == S_DATA) && w_selWvalid;
    assign m_WLAST   = (r_state == S_DATA) && (w_selWlast || w_lenDone);
    assign m_BREADY  = (r_state == S_RESP);

    assign s_AWREADY = (r_state == S_ADDR && m_AWREADY) ? r_grant : '0;
    assign s_WREADY  = (r_state == S_DATA && m_WREADY)  ? r_grant : '0;
    assign s_BVALID  = (r_state == S_RESP && m_BVALID)  ? r_grant : '0;

    always_comb begin
        s_BRESP = '0;
        for (int i = 0; i < N; i++)
            s_BRESP[2*i +: 2] = (r_state == S_RESP && r_grant[i]) ? m_BRESP : AXI_RESP_OKAY;
    end

    assign grant         = r_grant;
    assign protocolError = r_protocolError;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed and randomized bench for axi_write_arbiter.
// The reference model tracks pending bursts per master and picks winners by modular search.
module tb_axi_write_arbiter;
    import axi_write_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 128;

    logic                clk = 1'b0;
    logic                aresetn;
    logic [N*AW-1:0]     s_AWADDR;
    logic [N*8-1:0]      s_AWLEN;
    logic [N-1:0]        s_AWVALID, s_AWREADY;
    logic [N*DW-1:0]     s_WDATA;
    logic [N-1:0]        s_WLAST, s_WVALID, s_WREADY;
    logic [N*2-1:0]      s_BRESP;
    logic [N-1:0]        s_BVALID;
    logic [AW-1:0]       m_AWADDR;
    logic [7:0]          m_AWLEN;
    logic                m_AWVALID, m_AWREADY;
    logic [DW-1:0]       m_WDATA;
    logic                m_WLAST, m_WVALID, m_WREADY;
    logic [1:0]          m_BRESP;
    logic                m_BVALID, m_BREADY;
    logic [N-1:0]        grant;
    logic                protocolError, errorClear;

    always #5 clk = ~clk;

    axi_write_arbiter #(.NUM_MASTERS(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .clk(clk), .aresetn(aresetn),
        .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
        .s_WDATA(s_WDATA), .s_WLAST(s_WLAST), .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
        .s_BRESP(s_BRESP), .s_BVALID(s_BVALID),
        .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
        .m_WDATA(m_WDATA), .m_WLAST(m_WLAST), .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
        .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
        .grant(grant), .protocolError(protocolError), .errorClear(errorClear)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: one pending burst per master, the last winner and the sticky error.
    bit          pend [N];
    logic [31:0] maddr[N];
    logic [7:0]  mlen [N];
    int          mnb  [N];   // beats the master actually sends (WLAST on the last one)
    int          lastW;
    bit          errExp;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    function automatic logic [DW-1:0] wdat(input int m, input int b);
        return {8'(m), 24'h0, 32'(b), 64'hC0FFEE00_5A5A0000 + 64'(m * 256 + b)};
    endfunction

    function automatic int model_winner();
        for (int k = 1; k <= N; k++)
            if (pend[(lastW + k) % N]) return (lastW + k) % N;
        return -1;
    endfunction

    task automatic new_req(input int m, input int len, input int nb);
        pend[m]  = 1'b1;
        maddr[m] = $urandom;
        mlen[m]  = 8'(len);
        mnb[m]   = nb;
    endtask

    task automatic drive_masters(input int owner, input int beat);
        for (int i = 0; i < N; i++) begin
            s_AWVALID[i]         = pend[i];
            s_AWADDR[i*AW +: AW] = maddr[i];
            s_AWLEN[i*8 +: 8]    = mlen[i];
            if (i == owner) begin
                s_WDATA[i*DW +: DW] = wdat(i, beat);
                s_WLAST[i]          = (beat == mnb[i] - 1);
                s_WVALID[i]         = ($urandom_range(0, 3) != 0);
            end else begin
                s_WDATA[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
                s_WLAST[i]          = 1'($urandom_range(0, 1));
                s_WVALID[i]         = 1'b1;
            end
        end
    endtask

    // Runs one whole burst for the model's predicted winner; abort_at>0 pulls reset after that many beats.
    task automatic do_burst(input logic [1:0] bresp, input int abort_at, output logic [N-1:0] g);
        int ex, beat, term;
        bit got, done;
        logic [N-1:0]   gexp;
        logic [2*N-1:0] brexp;
        g    = '0;
        ex   = model_winner();
        if (ex < 0) begin timeout("no_requester"); return; end
        gexp = N'(1) << ex;
        term = (mnb[ex] - 1 < int'(mlen[ex])) ? mnb[ex] - 1 : int'(mlen[ex]);
        got  = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            drive_masters(-1, 0);
            m_AWREADY = 1'($urandom_range(0, 1));
            #1;
            if (m_AWVALID) begin
                g = grant;
                chk("aw_grant", grant, gexp);
                chk("aw_addr", m_AWADDR, maddr[ex]);
                chk("aw_len", m_AWLEN, mlen[ex]);
                chk("aw_ready", s_AWREADY, {N{m_AWREADY}} & gexp);
                got = m_AWREADY;
            end
        end
        if (!got) begin timeout("aw_wait"); return; end
        pend[ex] = 1'b0;
        beat = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            m_AWREADY = 1'b0;
            drive_masters(ex, beat);
            m_WREADY = ($urandom_range(0, 3) != 0);
            #1;
            chk("w_valid", m_WVALID, s_WVALID[ex]);
            chk("w_ready", s_WREADY, {N{m_WREADY}} & gexp);
            if (m_WVALID) begin
                chk("w_data", m_WDATA, wdat(ex, beat));
                chk("w_last", m_WLAST, beat == term);
            end
            if (m_WVALID && m_WREADY) begin
                if (beat == term) done = 1'b1;
                beat++;
                if (abort_at > 0 && beat == abort_at && !done) begin
                    @(negedge clk);
                    aresetn = 1'b0;
                    #1;
                    chk("rst_grant", grant, 0);
                    chk("rst_wvalid", m_WVALID, 0);
                    chk("rst_wready", s_WREADY, 0);
                    chk("rst_awvalid", m_AWVALID, 0);
                    chk("rst_bready", m_BREADY, 0);
                    chk("rst_perr", protocolError, 0);
                    return;
                end
            end
        end
        if (!done) begin timeout("w_wait"); return; end
        if (mnb[ex] - 1 != int'(mlen[ex])) errExp = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            m_WREADY = 1'b0;
            drive_masters(-1, 0);
            m_BRESP  = bresp;
            m_BVALID = (c >= 3) || ($urandom_range(0, 2) == 0);
            #1;
            chk("b_ready", m_BREADY, 1);
            chk("b_wvalid", m_WVALID, 0);
            chk("b_valid", s_BVALID, {N{m_BVALID}} & gexp);
            brexp = '0;
            brexp[2*ex +: 2] = bresp;
            chk("b_resp", s_BRESP, brexp);
            chk("perr", protocolError, errExp);
            got = m_BVALID;
        end
        if (!got) begin timeout("b_wait"); return; end
        lastW = ex;
        @(negedge clk);
        m_BVALID = 1'b0;
        m_BRESP  = 2'b00;
        drive_masters(-1, 0);
        #1;
        chk("idle_grant", grant, 0);
        chk("idle_awvalid", m_AWVALID, 0);
    endtask

    task automatic clear_err();
        @(negedge clk);
        errorClear = 1'b1;
        @(negedge clk);
        errorClear = 1'b0;
        #1;
        chk("perr_clear", protocolError, 0);
        errExp = 1'b0;
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        int order[6];
        order = '{0, 1, 2, 3, 0, 1};
        aresetn = 1'b0; errorClear = 1'b0;
        m_AWREADY = 1'b0; m_WREADY = 1'b0; m_BVALID = 1'b0; m_BRESP = 2'b00;
        s_AWADDR = '0; s_AWLEN = '0; s_AWVALID = '0; s_WDATA = '0; s_WLAST = '0; s_WVALID = '0;
        lastW = N - 1; errExp = 1'b0;
        for (int i = 0; i < N; i++) new_req(i, 0, 1);

        // Reset held with every master requesting
        drive_masters(-1, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_grant", grant, 0);
        chk("reset_awready", s_AWREADY, 0);
        chk("reset_wready", s_WREADY, 0);
        chk("reset_bvalid", s_BVALID, 0);
        chk("reset_awvalid", m_AWVALID, 0);
        chk("reset_wvalid", m_WVALID, 0);
        chk("reset_bready", m_BREADY, 0);
        chk("reset_perr", protocolError, 0);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        #1;
        chk("first_grant", grant, 4'b0001);

        // All four requesting continuously, single-beat bursts
        for (int k = 0; k < 6; k++) begin
            do_burst(2'b00, 0, g);
            chk("rr_order", g, N'(1) << order[k]);
            new_req(order[k], 0, 1);
        end
        while (any_pend()) do_burst(2'b00, 0, g);

        // Master 2 alone, 8-beat burst
        new_req(2, 7, 8);
        do_burst(AXI_RESP_OKAY, 0, g);
        chk("m2_grant", g, 4'b0100);

        // Early WLAST from master 1, then clear
        new_req(1, 7, 3);
        do_burst(AXI_RESP_OKAY, 0, g);
        chk("early_perr", protocolError, 1);
        clear_err();

        // Master 0 overruns its AWLEN; WLAST is forced on beat AWLEN+1
        new_req(0, 2, 6);
        do_burst(AXI_RESP_OKAY, 0, g);
        chk("late_perr", protocolError, 1);
        clear_err();

        // SLVERR forwarded to master 3 only
        new_req(3, 1, 2);
        do_burst(AXI_RESP_SLVERR, 0, g);

        // Reset in the middle of the data phase
        new_req(0, 7, 8);
        new_req(2, 0, 1);
        do_burst(AXI_RESP_OKAY, 4, g);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        lastW = N - 1; errExp = 1'b0;
        m_AWREADY = 1'b0; m_WREADY = 1'b0; m_BVALID = 1'b0;
        new_req(1, 3, 4);
        new_req(3, 1, 2);
        drive_masters(-1, 0);
        @(negedge clk);
        aresetn = 1'b1;
        do_burst(AXI_RESP_OKAY, 0, g);
        chk("post_rst_grant", g, 4'b0010);
        while (any_pend()) do_burst(AXI_RESP_OKAY, 0, g);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    int len, nb;
                    len = $urandom_range(0, 15);
                    nb  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 20) : len + 1;
                    new_req(i, len, nb);
                end
            end
            if (!any_pend()) new_req($urandom_range(0, N - 1), $urandom_range(0, 7), 0);
            for (int i = 0; i < N; i++) if (pend[i] && mnb[i] == 0) mnb[i] = int'(mlen[i]) + 1;
            drive_masters(-1, 0);
            do_burst(2'($urandom_range(0, 3)), 0, g);
            if (errExp && $urandom_range(0, 1) == 1) clear_err();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
